// File: rtl/prog_mem_loader.sv
// Serial boot loader: receives a framed image over UART (8N1), writes it into program memory
// from address 0x0000, and releases the CPU from reset once the frame checksum is valid.
module prog_mem_loader #(
    parameter int          CLKS_PER_BIT = 434,
    parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rxd,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_data,
    output logic        mem_cs_n,
    output logic        mem_wr_n,
    output logic        cpu_rst_n,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam int             CW        = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0]  BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0]  HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
    typedef enum logic [2:0] {ST_IDLE, ST_LEN_H, ST_LEN_L, ST_DATA, ST_CHK, ST_DONE, ST_ERR} state_e;

    // ------------------------------------------------------------------
    // UART receiver
    // ------------------------------------------------------------------
    logic            rx_meta_q, rx_sync_q, rx_prev_q;
    rx_state_e       rx_state_q;
    logic [CW-1:0]   clk_cnt_q;
    logic [2:0]      bit_idx_q;
    logic [7:0]      shift_q;
    logic            byte_vld_q, frm_err_q;

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q  <= 1'b1;
            rx_sync_q  <= 1'b1;
            rx_prev_q  <= 1'b1;
            rx_state_q <= RX_IDLE;
            clk_cnt_q  <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            byte_vld_q <= 1'b0;
            frm_err_q  <= 1'b0;
        end else begin
            rx_meta_q  <= rxd;
            rx_sync_q  <= rx_meta_q;
            rx_prev_q  <= rx_sync_q;
            byte_vld_q <= 1'b0;
            frm_err_q  <= 1'b0;
            case (rx_state_q)
                RX_IDLE: begin
                    if (rx_prev_q && !rx_sync_q) begin
                        rx_state_q <= RX_START;
                        clk_cnt_q  <= '0;
                    end
                end
                RX_START: begin
                    if (clk_cnt_q == HALF_LAST) begin
                        clk_cnt_q <= '0;
                        bit_idx_q <= '0;
                        // A start bit that is high again at mid-bit was only a glitch.
                        rx_state_q <= rx_sync_q ? RX_IDLE : RX_DATA;
                    end else begin
                        clk_cnt_q <= clk_cnt_q + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (clk_cnt_q == BIT_LAST) begin
                        clk_cnt_q <= '0;
                        shift_q   <= {rx_sync_q, shift_q[7:1]};
                        if (bit_idx_q == 3'd7) rx_state_q <= RX_STOP;
                        else                   bit_idx_q  <= bit_idx_q + 1'b1;
                    end else begin
                        clk_cnt_q <= clk_cnt_q + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (clk_cnt_q == BIT_LAST) begin
                        clk_cnt_q  <= '0;
                        byte_vld_q <= rx_sync_q;
                        frm_err_q  <= !rx_sync_q;
                        rx_state_q <= RX_IDLE;
                    end else begin
                        clk_cnt_q <= clk_cnt_q + 1'b1;
                    end
                end
                default: rx_state_q <= RX_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Frame parser and memory writer
    // ------------------------------------------------------------------
    state_e      state_q, state_d;
    logic [15:0] len_q, cnt_q, wr_addr_q;
    logic [7:0]  sum_q;
    logic [15:0] mem_addr_q;
    logic [7:0]  mem_data_q;
    logic        wr_pend_q, mem_cs_n_q, mem_wr_n_q;
    logic        cpu_rst_n_q, busy_q, done_q, err_q;
    logic        is_sync, last_data, sum_ok;

    assign is_sync   = byte_vld_q && (shift_q == SYNC_BYTE);
    assign last_data = (cnt_q == len_q - 16'd1);
    assign sum_ok    = ((sum_q + shift_q) == 8'h00);

    // NOTE: state_d gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (is_sync) state_d = ST_LEN_H;
            ST_LEN_H: begin
                if (frm_err_q)       state_d = ST_ERR;
                else if (byte_vld_q) state_d = ST_LEN_L;
            end
            ST_LEN_L: begin
                if (frm_err_q)       state_d = ST_ERR;
                else if (byte_vld_q) state_d = ({len_q[15:8], shift_q} != 16'd0) ? ST_DATA : ST_CHK;
            end
            ST_DATA: begin
                if (frm_err_q)                    state_d = ST_ERR;
                else if (byte_vld_q && last_data) state_d = ST_CHK;
            end
            ST_CHK: begin
                if (frm_err_q)       state_d = ST_ERR;
                else if (byte_vld_q) state_d = sum_ok ? ST_DONE : ST_ERR;
            end
            ST_DONE, ST_ERR: if (is_sync) state_d = ST_LEN_H;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            len_q       <= '0;
            cnt_q       <= '0;
            wr_addr_q   <= '0;
            sum_q       <= '0;
            mem_addr_q  <= '0;
            mem_data_q  <= '0;
            wr_pend_q   <= 1'b0;
            mem_cs_n_q  <= 1'b1;
            mem_wr_n_q  <= 1'b1;
            cpu_rst_n_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            busy_q     <= (state_d == ST_LEN_H) || (state_d == ST_LEN_L) ||
                          (state_d == ST_DATA)  || (state_d == ST_CHK);
            // Address/data settle one cycle before the single-cycle strobe.
            wr_pend_q  <= 1'b0;
            mem_cs_n_q <= !wr_pend_q;
            mem_wr_n_q <= !wr_pend_q;

            case (state_q)
                ST_LEN_H: if (byte_vld_q) len_q[15:8] <= shift_q;
                ST_LEN_L: if (byte_vld_q) len_q[7:0]  <= shift_q;
                ST_DATA: begin
                    if (byte_vld_q) begin
                        mem_addr_q <= wr_addr_q;
                        mem_data_q <= shift_q;
                        wr_pend_q  <= 1'b1;
                        wr_addr_q  <= wr_addr_q + 16'd1;
                        sum_q      <= sum_q + shift_q;
                        cnt_q      <= cnt_q + 16'd1;
                    end
                end
                default: ;
            endcase

            if (state_d != state_q) begin
                case (state_d)
                    ST_LEN_H: begin
                        sum_q       <= '0;
                        wr_addr_q   <= '0;
                        cnt_q       <= '0;
                        cpu_rst_n_q <= 1'b0;
                        done_q      <= 1'b0;
                        err_q       <= 1'b0;
                    end
                    ST_DONE: begin
                        cpu_rst_n_q <= 1'b1;
                        done_q      <= 1'b1;
                        err_q       <= 1'b0;
                    end
                    ST_ERR: begin
                        cpu_rst_n_q <= 1'b0;
                        done_q      <= 1'b0;
                        err_q       <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign mem_addr  = mem_addr_q;
    assign mem_data  = mem_data_q;
    assign mem_cs_n  = mem_cs_n_q;
    assign mem_wr_n  = mem_wr_n_q;
    assign cpu_rst_n = cpu_rst_n_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_prog_mem_loader.sv
// Bench for prog_mem_loader: UART frames are driven serially; writes are captured by a bus
// monitor and compared with expectations computed from each frame's data and checksum.
module tb_prog_mem_loader;

    localparam int         CPB  = 8;
    localparam logic [7:0] SYNC = 8'hA5;

    typedef logic [7:0] byte_q_t[$];

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rxd = 1'b1;
    logic [15:0] mem_addr;
    logic [7:0]  mem_data;
    logic        mem_cs_n, mem_wr_n, cpu_rst_n, busy, done, err;

    int checks = 0;
    int failures = 0;

    prog_mem_loader #(.CLKS_PER_BIT(CPB), .SYNC_BYTE(SYNC)) dut (
        .clk(clk), .rst_n(rst_n), .rxd(rxd),
        .mem_addr(mem_addr), .mem_data(mem_data), .mem_cs_n(mem_cs_n), .mem_wr_n(mem_wr_n),
        .cpu_rst_n(cpu_rst_n), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    // Bus monitor: logs every write strobe and counts protocol violations.
    logic [23:0] wr_log[$];
    int          viol = 0;
    logic        prev_strobe = 1'b0;
    always @(negedge clk) begin
        logic strobe;
        strobe = !mem_cs_n || !mem_wr_n;
        if (mem_cs_n !== mem_wr_n) viol++;
        if (strobe && prev_strobe) viol++;
        if (strobe) wr_log.push_back({mem_addr, mem_data});
        prev_strobe = strobe;
    end

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        rxd = 1'b0;
        repeat (CPB) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (CPB) @(posedge clk);
        end
        rxd = stop_bit;
        repeat (CPB) @(posedge clk);
        rxd = 1'b1;
        repeat (3) @(posedge clk);
    endtask

    task automatic expect_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Sends junk bytes then a full frame and checks writes and final status from the data/checksum.
    task automatic run_frame(input string name, input byte_q_t junk, input byte_q_t data,
                             input logic [7:0] chk);
        logic [7:0]  sum;
        logic        ok;
        logic [15:0] len;
        int          base_viol;
        int          n;
        wr_log.delete();
        base_viol = viol;
        len = 16'(data.size());
        foreach (junk[i]) send_byte(junk[i], 1'b1);
        send_byte(SYNC, 1'b1);
        expect_bit({name, " busy_after_sync"}, busy, 1'b1);
        send_byte(len[15:8], 1'b1);
        send_byte(len[7:0], 1'b1);
        foreach (data[i]) send_byte(data[i], 1'b1);
        send_byte(chk, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        sum = 8'h00;
        foreach (data[i]) sum = sum + data[i];
        ok = ((sum + chk) & 8'hFF) == 8'h00;
        checks++;
        if (wr_log.size() != data.size()) begin
            failures++;
            $display("FAIL %s write_count: got %0d expected %0d", name, wr_log.size(), data.size());
        end
        n = (wr_log.size() < data.size()) ? wr_log.size() : data.size();
        for (int i = 0; i < n; i++) begin
            checks++;
            if (wr_log[i] !== {16'(i), data[i]}) begin
                failures++;
                $display("FAIL %s write[%0d]: got addr=%h data=%h expected addr=%h data=%h",
                         name, i, wr_log[i][23:8], wr_log[i][7:0], 16'(i), data[i]);
            end
        end
        expect_bit({name, " done"}, done, ok);
        expect_bit({name, " err"}, err, !ok);
        expect_bit({name, " cpu_rst_n"}, cpu_rst_n, ok);
        expect_bit({name, " busy_end"}, busy, 1'b0);
        checks++;
        if (viol != base_viol) begin
            failures++;
            $display("FAIL %s strobe_protocol: got %0d violations expected 0", name, viol - base_viol);
        end
    endtask

    task automatic check_reset_values(input string name);
        checks++;
        if ({mem_addr, mem_data, mem_cs_n, mem_wr_n, cpu_rst_n, busy, done, err} !==
            {16'h0000, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL %s: got addr=%h data=%h cs_n=%b wr_n=%b cpu_rst_n=%b busy=%b done=%b err=%b expected 0000 00 1 1 0 0 0 0",
                     name, mem_addr, mem_data, mem_cs_n, mem_wr_n, cpu_rst_n, busy, done, err);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        rxd   = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_values("reset_values");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
    endtask

    task automatic test_good_frame();
        run_frame("good_frame", '{}, '{8'h11, 8'h22, 8'h33}, 8'h9A);
    endtask

    task automatic test_bad_checksum();
        run_frame("bad_checksum", '{}, '{8'h11, 8'h22, 8'h33}, 8'h9B);
        run_frame("recover_after_err", '{}, '{8'h11, 8'h22, 8'h33}, 8'h9A);
    endtask

    task automatic test_leading_junk();
        run_frame("leading_junk", '{8'h00, 8'hFF, 8'h5A}, '{8'h11, 8'h22, 8'h33}, 8'h9A);
    endtask

    task automatic test_frame_error();
        wr_log.delete();
        send_byte(SYNC, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h11, 1'b1);
        send_byte(8'h44, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (wr_log.size() != 1 || wr_log[0] !== 24'h0000_11) begin
            failures++;
            $display("FAIL frame_error writes: got count=%0d first=%h expected count=1 first=000011",
                     wr_log.size(), (wr_log.size() > 0) ? wr_log[0] : 24'h0);
        end
        expect_bit("frame_error err", err, 1'b1);
        expect_bit("frame_error busy", busy, 1'b0);
        expect_bit("frame_error done", done, 1'b0);
        // Short low pulse on an idle line must not be taken as a byte.
        rxd = 1'b0;
        repeat (2) @(posedge clk);
        rxd = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        checks++;
        if (wr_log.size() != 1) begin
            failures++;
            $display("FAIL glitch writes: got %0d expected 1", wr_log.size());
        end
        expect_bit("glitch err", err, 1'b1);
        expect_bit("glitch busy", busy, 1'b0);
        run_frame("recover_after_frm_err", '{}, '{8'h11, 8'h22, 8'h33}, 8'h9A);
    endtask

    task automatic test_reset_midframe();
        send_byte(SYNC, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h04, 1'b1);
        send_byte(8'hC1, 1'b1);
        send_byte(8'hC2, 1'b1);
        #3;
        rst_n = 1'b0;
        #1;
        check_reset_values("reset_midframe");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        run_frame("after_midframe_reset", '{}, '{8'h01, 8'h02, 8'h03, 8'h04}, 8'hF6);
    endtask

    task automatic test_zero_len();
        run_frame("zero_len", '{}, '{}, 8'h00);
    endtask

    task automatic test_random();
        for (int f = 0; f < 6; f++) begin
            byte_q_t     junk;
            byte_q_t     data;
            logic [7:0]  sum;
            logic [7:0]  chk;
            int          len;
            junk.delete();
            data.delete();
            for (int j = 0; j < int'($urandom_range(0, 2)); j++) begin
                logic [7:0] b;
                b = 8'($urandom_range(0, 255));
                if (b == SYNC) b = 8'h00;
                junk.push_back(b);
            end
            len = $urandom_range(1, 8);
            sum = 8'h00;
            for (int j = 0; j < len; j++) begin
                logic [7:0] b;
                b = 8'($urandom_range(0, 255));
                data.push_back(b);
                sum = sum + b;
            end
            chk = 8'h00 - sum;
            if ($urandom_range(0, 2) == 0) chk = chk + 8'($urandom_range(1, 255));
            run_frame($sformatf("random_%0d", f), junk, data, chk);
        end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_bad_checksum();
        test_leading_junk();
        test_frame_error();
        test_reset_midframe();
        test_zero_len();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
